// File: rtl/pcie_cfg_sampler_if.sv
// Configuration broadcast bundle between the PCIe hard IP and its application-side sampler.
// The master side drives the tl_cfg_* bus, and the slave side returns the decoded cfg_* fields.
interface pcie_cfg_sampler_if;
    logic [3:0]  tl_cfg_add;
    logic [31:0] tl_cfg_ctl;
    logic        tl_cfg_ctl_wr;
    logic [52:0] tl_cfg_sts;
    logic        tl_cfg_sts_wr;

    logic [12:0] cfg_busdev;
    logic [2:0]  cfg_max_payload;
    logic [2:0]  cfg_max_rd_req;
    logic        cfg_mem_en;
    logic        cfg_bus_master_en;
    logic        cfg_msi_en;
    logic [63:0] cfg_msi_addr;
    logic [15:0] cfg_msi_data;
    logic [1:0]  cfg_link_speed;
    logic [3:0]  cfg_link_width;
    logic        cfg_valid;
    logic        cfg_upd;
    logic [3:0]  cfg_upd_add;

    modport master (
        output tl_cfg_add, tl_cfg_ctl, tl_cfg_ctl_wr, tl_cfg_sts, tl_cfg_sts_wr,
        input  cfg_busdev, cfg_max_payload, cfg_max_rd_req, cfg_mem_en, cfg_bus_master_en,
               cfg_msi_en, cfg_msi_addr, cfg_msi_data, cfg_link_speed, cfg_link_width,
               cfg_valid, cfg_upd, cfg_upd_add
    );

    modport slave (
        input  tl_cfg_add, tl_cfg_ctl, tl_cfg_ctl_wr, tl_cfg_sts, tl_cfg_sts_wr,
        output cfg_busdev, cfg_max_payload, cfg_max_rd_req, cfg_mem_en, cfg_bus_master_en,
               cfg_msi_en, cfg_msi_addr, cfg_msi_data, cfg_link_speed, cfg_link_width,
               cfg_valid, cfg_upd, cfg_upd_add
    );
endinterface

// File: rtl/pcie_cfg_sampler.sv
// Samples the HIP time-multiplexed configuration and status buses after each wr toggle.
// The ctl and sts paths each have their own settle FSM and hold the decoded fields in registers.
module pcie_cfg_sampler #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                pld_clk_clk,
    input  logic                any_rstn,
    pcie_cfg_sampler_if.slave   cfg_if
);

    typedef enum logic {ST_IDLE, ST_SETTLE} state_t;

    localparam logic [2:0] LP_RELOAD = 3'(SETTLE_CYCLES - 1);

    function automatic logic [3:0] f_link_width(input logic [52:0] sts);
        logic [3:0] width;
        width = 4'd0;
        if (sts[35])      width = 4'd1;
        else if (sts[36]) width = 4'd2;
        else if (sts[37]) width = 4'd4;
        else if (sts[38]) width = 4'd8;
        return width;
    endfunction

    logic        r_armed;
    logic        r_ctl_wr_d;
    logic        r_sts_wr_d;
    state_t      r_ctl_state;
    state_t      r_sts_state;
    logic [2:0]  r_ctl_cnt;
    logic [2:0]  r_sts_cnt;

    logic [12:0] r_busdev;
    logic [2:0]  r_max_payload;
    logic [2:0]  r_max_rd_req;
    logic        r_mem_en;
    logic        r_bus_master_en;
    logic        r_msi_en;
    logic [63:0] r_msi_addr;
    logic [15:0] r_msi_data;
    logic [1:0]  r_link_speed;
    logic [3:0]  r_link_width;
    logic        r_valid;
    logic        r_upd;
    logic [3:0]  r_upd_add;

    logic        w_ctl_tgl;
    logic        w_sts_tgl;
    logic        w_unused_sts;

    // Toggle history is only trusted after one clock out of reset, so the first
    // edge after release just records the current wr levels.
    assign w_ctl_tgl    = r_armed & (cfg_if.tl_cfg_ctl_wr ^ r_ctl_wr_d);
    assign w_sts_tgl    = r_armed & (cfg_if.tl_cfg_sts_wr ^ r_sts_wr_d);
    assign w_unused_sts = ^{cfg_if.tl_cfg_sts[52:39], cfg_if.tl_cfg_sts[34:33],
                            cfg_if.tl_cfg_sts[30:0]};

    always_ff @(posedge pld_clk_clk or negedge any_rstn) begin
        if (!any_rstn) begin
            r_armed    <= 1'b0;
            r_ctl_wr_d <= 1'b0;
            r_sts_wr_d <= 1'b0;
        end else begin
            r_armed    <= 1'b1;
            r_ctl_wr_d <= cfg_if.tl_cfg_ctl_wr;
            r_sts_wr_d <= cfg_if.tl_cfg_sts_wr;
        end
    end

    // ctl path: settle countdown, then capture and decode the addressed register
    always_ff @(posedge pld_clk_clk or negedge any_rstn) begin
        if (!any_rstn) begin
            r_ctl_state     <= ST_IDLE;
            r_ctl_cnt       <= 3'd0;
            r_busdev        <= '0;
            r_max_payload   <= '0;
            r_max_rd_req    <= '0;
            r_mem_en        <= 1'b0;
            r_bus_master_en <= 1'b0;
            r_msi_en        <= 1'b0;
            r_msi_addr      <= '0;
            r_msi_data      <= '0;
            r_valid         <= 1'b0;
            r_upd           <= 1'b0;
            r_upd_add       <= '0;
        end else begin
            r_upd <= 1'b0;
            case (r_ctl_state)
                ST_IDLE: begin
                    if (w_ctl_tgl) begin
                        r_ctl_state <= ST_SETTLE;
                        r_ctl_cnt   <= LP_RELOAD;
                    end
                end
                ST_SETTLE: begin
                    if (r_ctl_cnt != 3'd0) begin
                        r_ctl_cnt <= w_ctl_tgl ? LP_RELOAD : r_ctl_cnt - 3'd1;
                    end else begin
                        r_upd     <= 1'b1;
                        r_upd_add <= cfg_if.tl_cfg_add;
                        case (cfg_if.tl_cfg_add)
                            4'h0: begin
                                r_max_payload <= cfg_if.tl_cfg_ctl[23:21];
                                r_max_rd_req  <= cfg_if.tl_cfg_ctl[30:28];
                            end
                            4'h3: begin
                                r_mem_en        <= cfg_if.tl_cfg_ctl[1];
                                r_bus_master_en <= cfg_if.tl_cfg_ctl[2];
                            end
                            4'h5: r_msi_addr[31:0]  <= cfg_if.tl_cfg_ctl;
                            4'h6: r_msi_addr[63:32] <= cfg_if.tl_cfg_ctl;
                            4'hD: begin
                                r_msi_en   <= cfg_if.tl_cfg_ctl[0];
                                r_msi_data <= cfg_if.tl_cfg_ctl[31:16];
                            end
                            4'hF: begin
                                r_busdev <= cfg_if.tl_cfg_ctl[12:0];
                                r_valid  <= 1'b1;
                            end
                            default: ;
                        endcase
                        // A toggle landing on the capture edge starts a fresh settle window
                        if (w_ctl_tgl) begin
                            r_ctl_cnt <= LP_RELOAD;
                        end else begin
                            r_ctl_state <= ST_IDLE;
                        end
                    end
                end
                default: r_ctl_state <= ST_IDLE;
            endcase
        end
    end

    // sts path: same settle behaviour, independent of the ctl path
    always_ff @(posedge pld_clk_clk or negedge any_rstn) begin
        if (!any_rstn) begin
            r_sts_state  <= ST_IDLE;
            r_sts_cnt    <= 3'd0;
            r_link_speed <= '0;
            r_link_width <= '0;
        end else begin
            case (r_sts_state)
                ST_IDLE: begin
                    if (w_sts_tgl) begin
                        r_sts_state <= ST_SETTLE;
                        r_sts_cnt   <= LP_RELOAD;
                    end
                end
                ST_SETTLE: begin
                    if (r_sts_cnt != 3'd0) begin
                        r_sts_cnt <= w_sts_tgl ? LP_RELOAD : r_sts_cnt - 3'd1;
                    end else begin
                        r_link_speed <= cfg_if.tl_cfg_sts[32:31];
                        r_link_width <= f_link_width(cfg_if.tl_cfg_sts);
                        if (w_sts_tgl) begin
                            r_sts_cnt <= LP_RELOAD;
                        end else begin
                            r_sts_state <= ST_IDLE;
                        end
                    end
                end
                default: r_sts_state <= ST_IDLE;
            endcase
        end
    end

    assign cfg_if.cfg_busdev        = r_busdev;
    assign cfg_if.cfg_max_payload   = r_max_payload;
    assign cfg_if.cfg_max_rd_req    = r_max_rd_req;
    assign cfg_if.cfg_mem_en        = r_mem_en;
    assign cfg_if.cfg_bus_master_en = r_bus_master_en;
    assign cfg_if.cfg_msi_en        = r_msi_en;
    assign cfg_if.cfg_msi_addr      = r_msi_addr;
    assign cfg_if.cfg_msi_data      = r_msi_data;
    assign cfg_if.cfg_link_speed    = r_link_speed;
    assign cfg_if.cfg_link_width    = r_link_width;
    assign cfg_if.cfg_valid         = r_valid;
    assign cfg_if.cfg_upd           = r_upd;
    assign cfg_if.cfg_upd_add       = r_upd_add;

endmodule

// File: tb/tb_pcie_cfg_sampler.sv
// Scoreboard bench for pcie_cfg_sampler: stimulus queues expected ctl captures,
// a negedge monitor pops one per cfg_upd pulse and checks it against a register-file model.
module tb_pcie_cfg_sampler;
    localparam int S = 2;

    typedef struct {
        logic [3:0]  add;
        logic [31:0] data;
        int          cyc;
    } item_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   upd_cnt = 0;
    int   pre;
    int   last_t = -100;

    logic [31:0] mem [16];
    bit          written [16];
    logic [52:0] sts_m;
    item_t       q [$];

    pcie_cfg_sampler_if u_if ();

    pcie_cfg_sampler #(.SETTLE_CYCLES(S)) dut (
        .pld_clk_clk (clk),
        .any_rstn    (rst_n),
        .cfg_if      (u_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] exp_width(input logic [52:0] s);
        if (s[35]) return 4'd1;
        if (s[36]) return 4'd2;
        if (s[37]) return 4'd4;
        if (s[38]) return 4'd8;
        return 4'd0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            mem[i]     = 32'h0;
            written[i] = 1'b0;
        end
        sts_m  = '0;
        last_t = -100;
        q.delete();
    endtask

    task automatic check_ctl(input string tag);
        chk({tag, "_busdev"},      64'(u_if.cfg_busdev),        64'(mem[15][12:0]));
        chk({tag, "_max_payload"}, 64'(u_if.cfg_max_payload),   64'(mem[0][23:21]));
        chk({tag, "_max_rd_req"},  64'(u_if.cfg_max_rd_req),    64'(mem[0][30:28]));
        chk({tag, "_mem_en"},      64'(u_if.cfg_mem_en),        64'(mem[3][1]));
        chk({tag, "_bm_en"},       64'(u_if.cfg_bus_master_en), 64'(mem[3][2]));
        chk({tag, "_msi_addr"},    u_if.cfg_msi_addr,           {mem[6], mem[5]});
        chk({tag, "_msi_data"},    64'(u_if.cfg_msi_data),      64'(mem[13][31:16]));
        chk({tag, "_msi_en"},      64'(u_if.cfg_msi_en),        64'(mem[13][0]));
        chk({tag, "_valid"},       64'(u_if.cfg_valid),         64'(written[15]));
    endtask

    task automatic check_all(input string tag);
        check_ctl(tag);
        chk({tag, "_link_speed"}, 64'(u_if.cfg_link_speed), 64'(sts_m[32:31]));
        chk({tag, "_link_width"}, 64'(u_if.cfg_link_width), 64'(exp_width(sts_m)));
        chk({tag, "_upd_idle"},   64'(u_if.cfg_upd),        64'd0);
    endtask

    // Expected capture edge is toggle edge + S; a retoggle inside the window replaces the pending one.
    task automatic queue_ctl(input logic [3:0] add, input logic [31:0] data);
        int t;
        t = cyc + 1;
        if (q.size() > 0 && (t - last_t) < S) void'(q.pop_back());
        q.push_back('{add: add, data: data, cyc: t + S});
        last_t = t;
        u_if.tl_cfg_add    = add;
        u_if.tl_cfg_ctl    = data;
        u_if.tl_cfg_ctl_wr = ~u_if.tl_cfg_ctl_wr;
    endtask

    task automatic do_ctl(input logic [3:0] add, input logic [31:0] data);
        @(posedge clk); #1;
        queue_ctl(add, data);
    endtask

    task automatic do_sts(input logic [52:0] s);
        @(posedge clk); #1;
        u_if.tl_cfg_sts    = s;
        u_if.tl_cfg_sts_wr = ~u_if.tl_cfg_sts_wr;
        sts_m = s;
    endtask

    task automatic do_both(input logic [3:0] add, input logic [31:0] data, input logic [52:0] s);
        @(posedge clk); #1;
        queue_ctl(add, data);
        u_if.tl_cfg_sts    = s;
        u_if.tl_cfg_sts_wr = ~u_if.tl_cfg_sts_wr;
        sts_m = s;
    endtask

    task automatic settle_chk(input int h, input string tag);
        repeat (h) @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    function automatic logic [52:0] rand_sts();
        return 53'({$urandom(), $urandom()});
    endfunction

    always @(negedge clk) begin
        item_t it;
        if (rst_n && u_if.cfg_upd === 1'b1) begin
            upd_cnt++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_upd: got upd with add 0x%0h, expected no capture (cycle %0d)",
                         u_if.cfg_upd_add, cyc);
            end else begin
                it = q.pop_front();
                mem[it.add]     = it.data;
                written[it.add] = 1'b1;
                chk("upd_cycle", 64'(cyc), 64'(it.cyc));
                chk("upd_add", 64'(u_if.cfg_upd_add), 64'(it.add));
                check_ctl("cap");
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [52:0] s;
        logic [52:0] s_old;
        logic [31:0] d;
        int          r;

        model_reset();
        u_if.tl_cfg_add    = 4'h0;
        u_if.tl_cfg_ctl    = 32'h0;
        u_if.tl_cfg_ctl_wr = 1'b0;
        u_if.tl_cfg_sts    = '0;
        u_if.tl_cfg_sts_wr = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("reset");
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Basic 0xF capture
        do_ctl(4'hF, 32'h0000_0A23);
        settle_chk(S + 6, "t1");
        chk("t1_busdev", 64'(u_if.cfg_busdev), 64'h0A23);
        chk("t1_valid", 64'(u_if.cfg_valid), 64'd1);
        chk("t1_upd_add", 64'(u_if.cfg_upd_add), 64'hF);

        // Full rotation through all 16 addresses
        pre = upd_cnt;
        for (int a = 0; a < 16; a++) begin
            d = $urandom();
            case (a)
                0:  begin d[23:21] = 3'b010; d[30:28] = 3'b101; end
                3:  d = 32'h0000_0006;
                5:  d = 32'hFEE0_0000;
                6:  d = 32'h0000_0001;
                13: d = 32'h4321_0001;
                default: ;
            endcase
            do_ctl(4'(a), d);
            settle_chk(S + 6, "rot");
        end
        chk("rot_upd_count", 64'(upd_cnt - pre), 64'd16);
        chk("rot_max_payload", 64'(u_if.cfg_max_payload), 64'd2);
        chk("rot_max_rd_req", 64'(u_if.cfg_max_rd_req), 64'd5);
        chk("rot_mem_en", 64'(u_if.cfg_mem_en), 64'd1);
        chk("rot_bm_en", 64'(u_if.cfg_bus_master_en), 64'd1);
        chk("rot_msi_addr", u_if.cfg_msi_addr, 64'h0000_0001_FEE0_0000);
        chk("rot_msi_data", 64'(u_if.cfg_msi_data), 64'h4321);
        chk("rot_msi_en", 64'(u_if.cfg_msi_en), 64'd1);

        // Retoggle inside the settle window
        pre = upd_cnt;
        do_ctl(4'h3, 32'h4);
        do_ctl(4'h3, 32'h2);
        settle_chk(S + 6, "retog");
        chk("retog_upd_count", 64'(upd_cnt - pre), 64'd1);
        chk("retog_mem_en", 64'(u_if.cfg_mem_en), 64'd1);
        chk("retog_bm_en", 64'(u_if.cfg_bus_master_en), 64'd0);

        // Status decode
        pre = upd_cnt;
        s = rand_sts();
        s[32:31] = 2'b10;
        s[38:35] = 4'b0100;
        do_sts(s);
        settle_chk(S + 6, "sts1");
        chk("sts1_speed", 64'(u_if.cfg_link_speed), 64'd2);
        chk("sts1_width", 64'(u_if.cfg_link_width), 64'd4);
        s[38:35] = 4'b0000;
        do_sts(s);
        settle_chk(S + 6, "sts2");
        chk("sts2_width", 64'(u_if.cfg_link_width), 64'd0);
        chk("sts_upd_count", 64'(upd_cnt - pre), 64'd0);

        // Simultaneous ctl and sts toggles
        pre   = upd_cnt;
        s_old = sts_m;
        s = '0;
        s[32:31] = 2'b01;
        s[38]    = 1'b1;
        do_both(4'h0, 32'h1040_0000, s);
        @(negedge clk);
        repeat (S) @(posedge clk);
        @(negedge clk);
        chk("sim_speed_before", 64'(u_if.cfg_link_speed), 64'(s_old[32:31]));
        @(negedge clk);
        chk("sim_upd", 64'(u_if.cfg_upd), 64'd1);
        chk("sim_speed", 64'(u_if.cfg_link_speed), 64'd1);
        chk("sim_width", 64'(u_if.cfg_link_width), 64'd8);
        settle_chk(S + 4, "sim");
        chk("sim_upd_count", 64'(upd_cnt - pre), 64'd1);

        // Randomized mix of ctl, sts and combined updates
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 2);
            d = $urandom();
            s = rand_sts();
            case (r)
                0: do_ctl(4'($urandom_range(0, 15)), d);
                1: do_sts(s);
                default: do_both(4'($urandom_range(0, 15)), d, s);
            endcase
            settle_chk($urandom_range(S + 2, S + 8), "rnd");
        end

        // Reset in the middle of a settle window
        do_ctl(4'hF, 32'h0000_1ABC);
        @(posedge clk); #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rst_async");
        chk("rst_valid", 64'(u_if.cfg_valid), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        pre = upd_cnt;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check_all("post_rst");
        chk("post_rst_upd_count", 64'(upd_cnt - pre), 64'd0);

        do_ctl(4'hF, 32'h0000_0123);
        settle_chk(S + 6, "rearm");
        chk("rearm_busdev", 64'(u_if.cfg_busdev), 64'h0123);

        repeat (S + 4) @(posedge clk);
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
